// File: rtl/dcm_prog_responder.sv
// Responder for the DCM_CLKGEN serial programming port: decodes LoadM/LoadD/GO
// frames, stages M/D codes and applies them after a modelled PROGDONE/LOCKED delay.
module dcm_prog_responder #(
   parameter int MULT_INIT  = 31,
   parameter int DIV_INIT   = 21,
   parameter int DONE_DELAY = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       progen,
   input  logic       progdata,
   output logic       progdone,
   output logic       locked,
   output logic [8:0] m_val,
   output logic [8:0] d_val,
   output logic       update,
   output logic       frame_err
);

   localparam int CW = (DONE_DELAY > 2) ? $clog2(DONE_DELAY) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_SHIFT, S_END, S_GO_CHK, S_BUSY, S_ERR_WAIT
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]   busy_cnt_q, busy_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            sel_m_q, sel_m_d;
   logic [7:0]      stage_m_q, stage_m_d;
   logic [7:0]      stage_d_q, stage_d_d;
   logic [8:0]      m_val_q, m_val_d;
   logic [8:0]      d_val_q, d_val_d;
   logic            update_q, update_d;
   logic            frame_err_q, frame_err_d;
   logic            progen_q;
   logic            busy_last;

   assign busy_last = (busy_cnt_q == CW'(DONE_DELAY - 1));

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (progen && !progen_q) state_d = progdata ? S_SEL : S_GO_CHK;
         S_SEL:      state_d = progen ? S_SHIFT : S_IDLE;
         S_SHIFT:    if (!progen) state_d = S_IDLE;
                     else if (bit_cnt_q == 3'd7) state_d = S_END;
         S_END:      state_d = progen ? S_ERR_WAIT : S_IDLE;
         S_GO_CHK:   state_d = progen ? S_ERR_WAIT : S_BUSY;
         S_BUSY:     if (busy_last) state_d = S_IDLE;
         S_ERR_WAIT: if (!progen) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Outputs: ready/locked are low exactly while a GO is being applied
   always_comb begin
      progdone  = (state_q != S_BUSY);
      locked    = (state_q != S_BUSY);
      m_val     = m_val_q;
      d_val     = d_val_q;
      update    = update_q;
      frame_err = frame_err_q;
   end

   // Datapath: shifting, staging, error detection and apply
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      busy_cnt_d  = busy_cnt_q;
      shift_d     = shift_q;
      sel_m_d     = sel_m_q;
      stage_m_d   = stage_m_q;
      stage_d_d   = stage_d_q;
      m_val_d     = m_val_q;
      d_val_d     = d_val_q;
      update_d    = 1'b0;
      frame_err_d = frame_err_q;
      unique case (state_q)
         S_SEL: begin
            sel_m_d   = progdata;
            bit_cnt_d = 3'd0;
            if (!progen) frame_err_d = 1'b1;
         end
         S_SHIFT: begin
            if (progen) begin
               shift_d   = {progdata, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         S_END: begin
            if (progen) begin
               frame_err_d = 1'b1;
            end else if (sel_m_q) begin
               // M code 0 would mean a multiplier of 1, which the DCM rejects
               if (shift_q == 8'd0) frame_err_d = 1'b1;
               else                 stage_m_d   = shift_q;
            end else begin
               stage_d_d = shift_q;
            end
         end
         S_GO_CHK: begin
            if (progen) frame_err_d = 1'b1;
            else        busy_cnt_d  = '0;
         end
         S_BUSY: begin
            if (progen && !progen_q) frame_err_d = 1'b1;
            if (busy_last) begin
               m_val_d  = {1'b0, stage_m_q} + 9'd1;
               d_val_d  = {1'b0, stage_d_q} + 9'd1;
               update_d = 1'b1;
            end else begin
               busy_cnt_d = busy_cnt_q + CW'(1);
            end
         end
         S_ERR_WAIT: frame_err_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q   <= 3'd0;
         busy_cnt_q  <= '0;
         shift_q     <= 8'd0;
         sel_m_q     <= 1'b0;
         stage_m_q   <= 8'(MULT_INIT - 1);
         stage_d_q   <= 8'(DIV_INIT - 1);
         m_val_q     <= 9'(MULT_INIT);
         d_val_q     <= 9'(DIV_INIT);
         update_q    <= 1'b0;
         frame_err_q <= 1'b0;
         progen_q    <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         busy_cnt_q  <= busy_cnt_d;
         shift_q     <= shift_d;
         sel_m_q     <= sel_m_d;
         stage_m_q   <= stage_m_d;
         stage_d_q   <= stage_d_d;
         m_val_q     <= m_val_d;
         d_val_q     <= d_val_d;
         update_q    <= update_d;
         frame_err_q <= frame_err_d;
         progen_q    <= progen;
      end
   end

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Directed bench for dcm_prog_responder: load/GO framing, apply latency,
// protocol errors, frames during BUSY and reset mid-BUSY.
module tb_dcm_prog_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       progen;
   logic       progdata;
   logic       progdone;
   logic       locked;
   logic [8:0] m_val;
   logic [8:0] d_val;
   logic       update;
   logic       frame_err;

   int checks   = 0;
   int failures = 0;

   dcm_prog_responder dut (
      .clk       (clk),
      .rst       (rst),
      .progen    (progen),
      .progdata  (progdata),
      .progdone  (progdone),
      .locked    (locked),
      .m_val     (m_val),
      .d_val     (d_val),
      .update    (update),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] load_word(input logic sel_m, input logic [7:0] code);
      return {code, sel_m, 1'b1};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      progen   = 1'b0;
      progdata = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Drives n bits (bit 0 first) then two idle cycles
   task automatic send_frame(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         progen   = 1'b1;
         progdata = bits[i];
         step();
      end
      progen   = 1'b0;
      progdata = 1'b0;
      step();
      step();
   endtask

   task automatic go_start();
      progen   = 1'b1;
      progdata = 1'b0;
      step();
      progen = 1'b0;
      step();
   endtask

   // Waits for progdone to rise and checks the applied values; exp_n < 0 skips latency check
   task automatic finish_go(input logic [8:0] em, input logic [8:0] ed, input int exp_n,
                            input string tag);
      int n = 0;
      int early_upd = 0;
      do begin
         step();
         n++;
         if (progdone === 1'b0 && update !== 1'b0) early_upd++;
      end while (progdone === 1'b0 && n < 1000);
      checks++;
      if (progdone !== 1'b1) begin
         failures++;
         $display("FAIL %s timeout: progdone=%b after %0d cycles, required 1", tag, progdone, n);
      end
      if (exp_n >= 0) begin
         checks++;
         if (n !== exp_n) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, required %0d", tag, n, exp_n);
         end
      end
      checks++;
      if (early_upd !== 0) begin
         failures++;
         $display("FAIL %s update_during_busy: got %0d pulses, required 0", tag, early_upd);
      end
      checks++;
      if (update !== 1'b1 || locked !== 1'b1) begin
         failures++;
         $display("FAIL %s release: update=%b locked=%b, required 1 1", tag, update, locked);
      end
      checks++;
      if (m_val !== em || d_val !== ed) begin
         failures++;
         $display("FAIL %s values: m=%0d d=%0d, required m=%0d d=%0d", tag, m_val, d_val, em, ed);
      end
      step();
      checks++;
      if (update !== 1'b0 || progdone !== 1'b1) begin
         failures++;
         $display("FAIL %s pulse_width: update=%b progdone=%b, required 0 1", tag, update, progdone);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (m_val !== 9'd31 || d_val !== 9'd21) begin
         failures++;
         $display("FAIL reset_md: m=%0d d=%0d, required 31 21", m_val, d_val);
      end
      checks++;
      if (progdone !== 1'b1 || locked !== 1'b1 || update !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: progdone=%b locked=%b update=%b frame_err=%b, required 1 1 0 0",
                  progdone, locked, update, frame_err);
      end
   endtask

   task automatic test_load_go();
      do_reset();
      send_frame({22'd0, load_word(1'b1, 8'h2F)}, 10);
      send_frame({22'd0, load_word(1'b0, 8'h13)}, 10);
      go_start();
      checks++;
      if (progdone !== 1'b0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL go_busy_entry: progdone=%b locked=%b, required 0 0", progdone, locked);
      end
      finish_go(9'd48, 9'd20, 64, "load_go");
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL load_go_err: frame_err=%b, required 0", frame_err);
      end
   endtask

   task automatic test_d_max();
      do_reset();
      send_frame({22'd0, load_word(1'b0, 8'hFF)}, 10);
      go_start();
      finish_go(9'd31, 9'd256, 64, "d_max");
   endtask

   task automatic test_short_frame();
      do_reset();
      send_frame({22'd0, load_word(1'b1, 8'h55)}, 6);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL short_err: frame_err=%b, required 1", frame_err);
      end
      go_start();
      finish_go(9'd31, 9'd21, 64, "short_go");
   endtask

   task automatic test_bad_frames();
      do_reset();
      send_frame({22'd0, load_word(1'b1, 8'h00)}, 10);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL m_zero_err: frame_err=%b, required 1", frame_err);
      end
      go_start();
      finish_go(9'd31, 9'd21, -1, "m_zero_go");
      do_reset();
      send_frame({20'd0, 2'b11, load_word(1'b1, 8'h05)}, 12);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL long_err: frame_err=%b, required 1", frame_err);
      end
      go_start();
      finish_go(9'd31, 9'd21, -1, "long_go");
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame({22'd0, load_word(1'b1, 8'h10)}, 10);
      send_frame({22'd0, load_word(1'b1, 8'h20)}, 10);
      go_start();
      finish_go(9'd33, 9'd21, -1, "last_wins");
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL last_wins_err: frame_err=%b, required 0", frame_err);
      end
      // LoadM immediately followed by LoadD with no idle gap: over-length error
      send_frame({12'd0, load_word(1'b0, 8'h40), load_word(1'b1, 8'h07)}, 20);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL b2b_err: frame_err=%b, required 1", frame_err);
      end
      go_start();
      finish_go(9'd33, 9'd21, -1, "b2b_go");
   endtask

   task automatic test_busy_and_rst();
      do_reset();
      go_start();
      send_frame({22'd0, load_word(1'b1, 8'h40)}, 10);
      checks++;
      if (frame_err !== 1'b1 || progdone !== 1'b0) begin
         failures++;
         $display("FAIL busy_frame: frame_err=%b progdone=%b, required 1 0", frame_err, progdone);
      end
      finish_go(9'd31, 9'd21, -1, "busy_frame_go");
      send_frame({22'd0, load_word(1'b1, 8'h2F)}, 10);
      go_start();
      repeat (9) step();
      rst = 1'b1;
      step();
      checks++;
      if (progdone !== 1'b1 || locked !== 1'b1 || update !== 1'b0 || frame_err !== 1'b0 ||
          m_val !== 9'd31 || d_val !== 9'd21) begin
         failures++;
         $display("FAIL rst_mid_busy: progdone=%b locked=%b update=%b err=%b m=%0d d=%0d, required 1 1 0 0 31 21",
                  progdone, locked, update, frame_err, m_val, d_val);
      end
      rst = 1'b0;
      step();
      go_start();
      finish_go(9'd31, 9'd21, 64, "post_rst_go");
   endtask

   initial begin
      rst      = 1'b1;
      progen   = 1'b0;
      progdata = 1'b0;
      test_reset();
      test_load_go();
      test_d_max();
      test_short_frame();
      test_bad_frames();
      test_back_to_back();
      test_busy_and_rst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcm_prog_responder.md
Name: dcm_prog_responder

Overview:
- Responder end of the DCM_CLKGEN serial programming port (PROGEN/PROGDATA/PROGDONE), sampled on the programming clock.
- Decodes LoadD, LoadM and GO frames issued by the SPI programming controller and stages the M/D values.
- Models PROGDONE/LOCKED timing, then presents the applied multiplier/divider.
- Used as the bench-side DCM model for the frequency generator and as a frequency-word source for non-DCM targets.

Parameters:
- MULT_INIT, 31, applied multiplier after reset.
- DIV_INIT, 21, applied divider after reset.
- DONE_DELAY, 64, cycles PROGDONE/LOCKED stay low after an accepted GO (min 2).

Ports:
- clk  input  1  programming clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- progen  input  1  frame enable from programming controller.
- progdata  input  1  serial command/data bit, sampled while progen=1.
- progdone  output  1  ready for next command; low while a GO is being applied.
- locked  output  1  output-frequency-valid flag.
- m_val  output  9  applied multiplier (code+1, range 2..256).
- d_val  output  9  applied divider (code+1, range 1..256).
- update  output  1  one-cycle pulse when m_val/d_val change.
- frame_err  output  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Reset values:
  - progdone=1, locked=1, m_val=MULT_INIT, d_val=DIV_INIT, update=0, frame_err=0.
  - Staged M/D = applied values; state IDLE.
- Frame framing: a frame is the contiguous run of cycles with progen=1. Bit 0 is the first cycle progen is high.
- Load frame: exactly 10 bits.
  - b0=1, b1 selects register (1=M, 0=D).
  - b2..b9 = 8-bit code, LSB first.
- GO frame: exactly 1 bit with progdata=0.
- States:
  - IDLE: progen rise with bit=1 -> SEL; with bit=0 -> GO_CHK.
  - SEL: capture select -> SHIFT, count=0.
  - SHIFT: shift 8 bits; after bit 9 -> END.
  - END: progen=0 commits staged reg -> IDLE. progen=1 (11th bit) -> ERR_WAIT.
  - GO_CHK: progen=0 -> BUSY, progdone=0 and locked=0 on that same cycle. progen=1 -> ERR_WAIT.
  - BUSY: count DONE_DELAY cycles. On the last one, load m_val=stagedM+1 and d_val=stagedD+1, pulse update, set progdone=1 and locked=1 next cycle -> IDLE.
  - ERR_WAIT: set frame_err; discard frame; wait for progen=0 -> IDLE.
- Short load frame (progen drops in SEL/SHIFT): frame_err=1, frame discarded, staged value unchanged.
- M code 0 (M=1) is illegal: frame_err=1, staged M unchanged.
- Any frame starting while in BUSY is ignored entirely (no staging) and sets frame_err. Its cycles are consumed until progen=0.
- Successive loads to the same register before GO: last one wins.
- GO with no prior load reapplies current values; the full busy cycle and update pulse still occur.
- Back-to-back frames require ≥1 cycle of progen=0; a frame whose first bit follows END directly is an over-length error.
- rst mid-frame or mid-BUSY: immediate return to reset values; staged values lost.
- Latency: GO falling edge to progdone rise = DONE_DELAY+1 cycles; update coincides with the m_val/d_val change.

Test Plan:
- After rst: m_val=31, d_val=21, progdone=1, locked=1, frame_err=0, no update.
- LoadM code 0x2F, LoadD code 0x13, GO -> progdone low next cycle for 64 cycles, then m_val=48, d_val=20, one update pulse, locked=1.
- LoadD code 0xFF, GO -> d_val=256, m_val unchanged at 31.
- LoadM truncated after 6 bits -> frame_err=1; a subsequent GO leaves m_val=31.
- LoadM code 0x00 -> frame_err=1; a 12-bit frame also sets frame_err. Neither changes staged values.
- Issue a LoadM during BUSY -> ignored with frame_err=1. Then rst asserted at cycle 10 of a second BUSY -> all outputs return to reset values the next cycle.
